// File: rtl/bcd_convert_arbiter.sv
// bcd_convert_arbiter: shares one external combinational binary-to-BCD
// converter among several requesters. Requests are granted round-robin. The
// operand (sign removed) is held on the converter input for a programmable
// settle time. The 11 captured digits are then returned with a valid/ready
// handshake that carries the owning requester's index.
module bcd_convert_arbiter #(
  parameter int NUM_REQ       = 3,
  parameter int ID_W          = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_data,
  input  logic [NUM_REQ-1:0]     req_signed,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [31:0]            conv_bits,
  input  logic [43:0]            conv_digits,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [ID_W-1:0]        result_id,
  output logic [43:0]            result_digits,
  output logic                   result_neg,
  output logic                   busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_nextState;

  logic [PTR_W-1:0]   r_rrPtr;
  logic [PTR_W-1:0]   w_grant;
  logic [PTR_W-1:0]   w_nextPtr;
  logic               w_grantFound;
  logic               w_accept;
  logic               w_captureNow;

  logic [31:0]        w_grantData;
  logic               w_grantNeg;
  logic [31:0]        w_magnitude;

  logic [31:0]        r_operand;
  logic [3:0]         r_cnt;
  logic [ID_W-1:0]    r_id;
  logic [43:0]        r_digits;
  logic               r_neg;

  // Round-robin search: first valid requester at or after the pointer, wrapping
  always_comb begin : grantSearch
    int idx;
    idx          = 0;
    w_grantFound = 1'b0;
    w_grant      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(r_rrPtr) + k) % NUM_REQ;
      if (!w_grantFound && req_valid[idx]) begin
        w_grantFound = 1'b1;
        w_grant      = PTR_W'(idx);
      end
    end
  end

  // Operand of the granted requester, with the sign stripped for signed negatives
  assign w_grantData = req_data[32*w_grant +: 32];
  assign w_grantNeg  = req_signed[w_grant] & w_grantData[31];
  assign w_magnitude = w_grantNeg ? (~w_grantData + 32'd1) : w_grantData;
  assign w_nextPtr   = (w_grant == PTR_W'(NUM_REQ - 1)) ? '0 : (w_grant + 1'b1);

  // Next-state and handshake decode; ready is suppressed while reset is held
  always_comb begin
    w_nextState  = r_state;
    w_accept     = 1'b0;
    w_captureNow = 1'b0;
    req_ready    = '0;
    case (r_state)
      IDLE: begin
        if (w_grantFound && !reset) begin
          w_accept    = 1'b1;
          req_ready   = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_grant;
          w_nextState = SETTLE;
        end
      end
      SETTLE: begin
        if (r_cnt == 4'd0) begin
          w_captureNow = 1'b1;
          w_nextState  = DONE;
        end
      end
      DONE: begin
        if (result_ready) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Datapath: latch the operand on accept, count the settle time, capture the digits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_operand <= '0;
      r_neg     <= 1'b0;
      r_id      <= '0;
      r_rrPtr   <= '0;
      r_cnt     <= '0;
      r_digits  <= '0;
    end else if (w_accept) begin
      r_operand <= w_magnitude;
      r_neg     <= w_grantNeg;
      r_id      <= ID_W'(w_grant);
      r_rrPtr   <= w_nextPtr;
      r_cnt     <= 4'(SETTLE_CYCLES - 1);
    end else if (r_state == SETTLE) begin
      if (w_captureNow) begin
        r_digits <= conv_digits;
      end else begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  assign conv_bits     = r_operand;
  assign result_valid  = (r_state == DONE);
  assign result_id     = r_id;
  assign result_digits = r_digits;
  assign result_neg    = r_neg;
  assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// Testbench for bcd_convert_arbiter: behavioural converter model on conv_bits,
// directed requests, and a queue-based scoreboard checked by a result monitor.
module tb_bcd_convert_arbiter;

  localparam int NUM_REQ = 3;
  localparam int ID_W    = 2;
  localparam int SETTLE  = 2;
  localparam int LIMIT   = 60;

  logic                  clk;
  logic                  reset;
  logic [NUM_REQ-1:0]    req_valid;
  logic [32*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    req_signed;
  logic [NUM_REQ-1:0]    req_ready;
  logic [31:0]           conv_bits;
  logic [43:0]           conv_digits;
  logic                  result_valid;
  logic                  result_ready;
  logic [ID_W-1:0]       result_id;
  logic [43:0]           result_digits;
  logic                  result_neg;
  logic                  busy;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [43:0]     digits;
    logic            neg;
  } exp_t;

  exp_t expQ[$];
  int   total = 0;
  int   bad   = 0;

  bcd_convert_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W(ID_W),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_signed(req_signed),
    .req_ready(req_ready),
    .conv_bits(conv_bits),
    .conv_digits(conv_digits),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .result_id(result_id),
    .result_digits(result_digits),
    .result_neg(result_neg),
    .busy(busy)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural combinational binary-to-BCD converter (double dabble)
  function automatic logic [43:0] bin2bcd(input logic [31:0] b);
    logic [43:0] d;
    d = '0;
    for (int i = 31; i >= 0; i--) begin
      for (int k = 0; k < 11; k++) begin
        if (d[4*k +: 4] >= 4'd5) d[4*k +: 4] = d[4*k +: 4] + 4'd3;
      end
      d = {d[42:0], b[i]};
    end
    return d;
  endfunction

  assign conv_digits = bin2bcd(conv_bits);

  task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic pushExp(input int id, input logic [43:0] digits, input logic neg);
    exp_t e;
    e.id     = ID_W'(id);
    e.digits = digits;
    e.neg    = neg;
    expQ.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for any grant, then check it is the expected one-hot strobe
  task automatic waitGrant(input logic [NUM_REQ-1:0] expReady, input string name);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < LIMIT; n++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        seen = 1'b1;
        break;
      end
    end
    if (seen) compare(name, 64'(req_ready), 64'(expReady));
    else failNow(name);
  endtask

  task automatic waitIdle(input string name);
    bit done;
    done = 1'b0;
    for (int n = 0; n < LIMIT; n++) begin
      tick();
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) failNow(name);
  endtask

  task automatic checkResetOutputs(input string tag);
    compare({tag, " busy"},          64'(busy),          64'd0);
    compare({tag, " result_valid"},  64'(result_valid),  64'd0);
    compare({tag, " req_ready"},     64'(req_ready),     64'd0);
    compare({tag, " conv_bits"},     64'(conv_bits),     64'd0);
    compare({tag, " result_digits"}, 64'(result_digits), 64'd0);
    compare({tag, " result_id"},     64'(result_id),     64'd0);
    compare({tag, " result_neg"},    64'(result_neg),    64'd0);
  endtask

  // One request from one requester: grant, one-cycle ready, operand, latency, drain
  task automatic applyStimulus(input int idx, input logic [31:0] data, input logic sgn,
                               input logic [43:0] expDigits, input logic expNeg,
                               input string name);
    logic [31:0] expMag;
    int edges;
    bit rose;
    expMag = (sgn && data[31]) ? (~data + 32'd1) : data;
    pushExp(idx, expDigits, expNeg);
    req_data[idx*32 +: 32] = data;
    req_signed[idx]        = sgn;
    req_valid[idx]         = 1'b1;
    waitGrant(NUM_REQ'(1) << idx, {name, " grant"});
    tick();
    req_valid[idx] = 1'b0;
    @(negedge clk);
    compare({name, " ready one cycle"}, 64'(req_ready), 64'd0);
    compare({name, " conv_bits"},       64'(conv_bits), 64'(expMag));
    edges = 0;
    rose  = 1'b0;
    for (int n = 0; n < LIMIT; n++) begin
      tick();
      edges++;
      if (result_valid) begin
        rose = 1'b1;
        break;
      end
    end
    if (rose) compare({name, " latency"}, 64'(edges), 64'(SETTLE));
    else failNow({name, " latency"});
    waitIdle({name, " idle"});
  endtask

  // Scoreboard check of one delivered result
  task automatic checkOutput();
    exp_t e;
    if (expQ.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL unexpected result: got id %0h digits %0h expected none", result_id, result_digits);
    end else begin
      e = expQ.pop_front();
      compare("result_id",     64'(result_id),     64'(e.id));
      compare("result_digits", 64'(result_digits), 64'(e.digits));
      compare("result_neg",    64'(result_neg),    64'(e.neg));
    end
  endtask

  // Monitor: a result is consumed whenever valid and ready are both high
  always @(negedge clk) begin
    if (result_valid && result_ready) checkOutput();
  end

  // Watchdog so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  gIdx[4];
    time gTime[4];
    bit  seen;

    reset        = 1'b1;
    req_valid    = '0;
    req_data     = '0;
    req_signed   = '0;
    result_ready = 1'b0;
    #2;
    checkResetOutputs("reset");
    tick();
    reset = 1'b0;

    // Basic unsigned conversion
    result_ready = 1'b1;
    applyStimulus(0, 32'h0000_04D2, 1'b0, 44'h000_0000_1234, 1'b0, "t1 1234");

    // Signed and boundary operands
    applyStimulus(1, 32'hFFFF_FFFF, 1'b1, 44'h000_0000_0001, 1'b1, "t2 minus one");
    applyStimulus(1, 32'h8000_0000, 1'b1, 44'h021_4748_3648, 1'b1, "t2 min int");
    applyStimulus(1, 32'hFFFF_FFFF, 1'b0, 44'h042_9496_7295, 1'b0, "t2 max uns");

    // Round-robin with all requesters held valid after a reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    gIdx[0] = 0; gIdx[1] = 1; gIdx[2] = 2; gIdx[3] = 0;
    req_data[31:0]  = 32'd7;
    req_data[63:32] = 32'd42;
    req_data[95:64] = 32'd65535;
    req_signed      = '0;
    pushExp(0, 44'h7, 1'b0);
    pushExp(1, 44'h42, 1'b0);
    pushExp(2, 44'h65535, 1'b0);
    pushExp(0, 44'h7, 1'b0);
    req_valid = 3'b111;
    for (int g = 0; g < 4; g++) begin
      seen = 1'b0;
      for (int n = 0; n < LIMIT; n++) begin
        @(negedge clk);
        if (req_ready != '0) begin
          seen = 1'b1;
          break;
        end
      end
      gTime[g] = $time;
      if (seen) compare($sformatf("t3 grant %0d", g), 64'(req_ready), 64'(NUM_REQ'(1) << gIdx[g]));
      else failNow($sformatf("t3 grant %0d", g));
    end
    compare("t3 throughput", 64'(gTime[2] - gTime[1]), 64'((SETTLE + 2) * 10));
    tick();
    req_valid = '0;
    waitIdle("t3 idle");

    // Pointer now at 1: req2 wins over req0
    req_data[31:0]  = 32'd5;
    req_data[95:64] = 32'd12;
    pushExp(2, 44'h12, 1'b0);
    pushExp(0, 44'h5, 1'b0);
    req_valid = 3'b101;
    waitGrant(3'b100, "t4 first grant");
    tick();
    req_valid[2] = 1'b0;
    waitGrant(3'b001, "t4 second grant");
    tick();
    req_valid[0] = 1'b0;
    waitIdle("t4 idle");

    // Back-pressure in DONE
    result_ready    = 1'b0;
    req_data[31:0]  = 32'd12345;
    pushExp(0, 44'h12345, 1'b0);
    req_valid[0] = 1'b1;
    waitGrant(3'b001, "t5 grant");
    tick();
    req_valid[0] = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < LIMIT; n++) begin
      tick();
      if (result_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) failNow("t5 result_valid");
    req_data[63:32] = 32'd99;
    pushExp(1, 44'h99, 1'b0);
    req_valid[1] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      compare("t5 hold valid",     64'(result_valid),  64'd1);
      compare("t5 hold digits",    64'(result_digits), 64'h12345);
      compare("t5 hold id",        64'(result_id),     64'd0);
      compare("t5 hold req_ready", 64'(req_ready),     64'd0);
      compare("t5 hold conv_bits", 64'(conv_bits),     64'd12345);
    end
    tick();
    result_ready = 1'b1;
    @(negedge clk);
    compare("t5 no accept at handshake", 64'(req_ready), 64'd0);
    @(negedge clk);
    compare("t5 grant after idle", 64'(req_ready), 64'b010);
    tick();
    req_valid[1] = 1'b0;
    waitIdle("t5 idle");

    // Reset in the middle of SETTLE discards the conversion
    req_data[95:64] = 32'd9999;
    req_valid[2]    = 1'b1;
    waitGrant(3'b100, "t6 grant");
    tick();
    compare("t6 in settle", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    checkResetOutputs("t6 reset");
    tick();
    tick();
    reset = 1'b0;
    pushExp(2, 44'h9999, 1'b0);
    waitGrant(3'b100, "t6 regrant");
    tick();
    req_valid[2] = 1'b0;
    waitIdle("t6 idle");

    tick();
    compare("queue drained", 64'(expQ.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_convert_arbiter.md
Name: bcd_convert_arbiter

Overview:
Sequential controller that shares one combinational 32-bit binary-to-BCD converter (11 BCD digits out) among several result producers: multiplier, divider and square-root units. It grants requesters round-robin, holds the operand stable on the converter input for a programmable settle time, and captures the 11 digits into a result register. It returns the digits with a valid/ready handshake tagged with the requester ID. Signed operands are converted as sign plus magnitude.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
ID_W, 2, width of result_id; must be at least clog2(NUM_REQ)
SETTLE_CYCLES, 2, cycles the operand is held on the converter before capture (1..15); covers the converter's multicycle path

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  NUM_REQ  per-requester request; held with data until accepted
req_data  input  32*NUM_REQ  operand of requester i at [32i+31:32i]
req_signed  input  NUM_REQ  1 = treat operand as two's complement
req_ready  output  NUM_REQ  one-hot accept strobe
conv_bits  output  32  operand driven to the converter's binary input
conv_digits  input  44  converter outputs packed {out11,...,out1}; nibble k = 10^k digit
result_valid  output  1  result available
result_ready  input  1  consumer accepts result
result_id  output  ID_W  index of the requester that owns the result
result_digits  output  44  captured BCD digits; nibble k = 10^k
result_neg  output  1  operand was negative (signed request only)
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset values (asynchronous, immediate): state IDLE; rr_ptr 0; operand register 0, so conv_bits = 0; settle counter 0; all outputs 0.
- FSM states: IDLE, SETTLE, DONE.
- IDLE:
  - grant = first i with req_valid[i], searching from rr_ptr upward modulo NUM_REQ.
  - req_ready[grant] = 1 combinationally, all other bits 0. No valid bit set -> req_ready = 0.
  - On an accepting edge:
    - If req_signed[grant] and data[31] = 1: operand <= (~data + 1), neg <= 1.
    - Otherwise: operand <= data, neg <= 0.
    - id <= grant; rr_ptr <= (grant + 1) mod NUM_REQ; cnt <= SETTLE_CYCLES - 1; state -> SETTLE.
- SETTLE:
  - conv_bits = operand, stable throughout.
  - Each edge: if cnt == 0, result_digits <= conv_digits and state -> DONE; else cnt <= cnt - 1.
- DONE:
  - result_valid = 1. result_id, result_digits and result_neg hold stable until the handshake.
  - On an edge with result_ready = 1: state -> IDLE.
  - req_ready stays 0 until back in IDLE; there is no accept in the same cycle as a result handshake.
- Latency: result_valid rises exactly SETTLE_CYCLES edges after the accept edge.
- Throughput: one conversion per SETTLE_CYCLES + 2 cycles when result_ready is held high.
- Magnitude of 0x80000000 signed is 2147483648; it fits unsigned 32 bits, so there is no overflow case.
- Unsigned max 0xFFFFFFFF converts to 10 significant digits; nibble 10 is 0.
- conv_bits changes only on an accept edge, never during SETTLE or DONE.
- A requester dropping req_valid before being granted is legal and simply skipped. Dropping it after req_ready has been seen is a protocol violation, not checked.
- Reset during SETTLE or DONE: the in-flight conversion is discarded and no result is produced. The pending requester must re-request and is regranted from rr_ptr = 0.
- req_data, req_signed and result_ready are ignored outside IDLE and DONE respectively.

Test Plan:
1. SETTLE_CYCLES=2; req0 valid, data 0x000004D2, unsigned -> req_ready=001 one cycle; result_valid 2 edges after accept; result_digits=0x00000001234, id=0, neg=0.
2. req1 signed 0xFFFFFFFF -> digits 0x00000000001, neg=1. Then req1 signed 0x80000000 -> digits 0x02147483648, neg=1. Then req1 unsigned 0xFFFFFFFF -> digits 0x04294967295, neg=0.
3. After reset, all three req_valid held high, result_ready=1 -> grants in order 0,1,2,0. Each result_id matches its grant; rr_ptr returns to 0 after grant 2.
4. With rr_ptr=1, only req0 and req2 valid -> req2 granted first, then req0.
5. result_ready low for 5 cycles in DONE -> result_valid, result_digits and result_id constant; req_ready=0 and conv_bits unchanged throughout. result_ready high -> IDLE on the next edge, grant on the following cycle.
6. reset pulsed mid-SETTLE on a 9999 conversion -> all outputs 0 immediately, busy=0, no result emitted. After release, a still-valid req2 is granted and its result (0x00000009999) is delivered.
